// File: rtl/sh_mem_banked_pkg.sv
// sh_mem_banked shared definitions: default sizes,
// per-core enable encodings and conflict counter width.
package sh_mem_banked_pkg;

  localparam int DEF_NUM_CORES  = 4;
  localparam int DEF_NUM_BANKS  = 4;
  localparam int DEF_BANK_DEPTH = 256;
  localparam int DEF_DATA_W     = 8;
  localparam int CNT_W          = 16;

  typedef enum logic [1:0] {
    EN_IDLE  = 2'b00,
    EN_RD    = 2'b01,
    EN_WR    = 2'b10,
    EN_WR_NR = 2'b11
  } en_e;

endpackage

// File: rtl/sh_mem_banked_bank.sv
// sh_mem_bank: single-port storage bank,
// write or registered 1-cycle read per clock.
module sh_mem_bank
  import sh_mem_banked_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_BANK_DEPTH,
  localparam int OFF_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [OFF_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // one access per cycle: write wins, else registered read
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sh_mem_banked.sv
// sh_mem_banked: multi-core banked memory, round-robin per bank.
// Optional per-bank conflict counters via SH_MEM_CONFLICT_CNT_EN.
module sh_mem_banked
  import sh_mem_banked_pkg::*;
#(
  parameter int NUM_CORES  = DEF_NUM_CORES,
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int BANK_DEPTH = DEF_BANK_DEPTH,
  parameter int DATA_W     = DEF_DATA_W,
  localparam int BANK_W    = $clog2(NUM_BANKS),
  localparam int OFF_W     = $clog2(BANK_DEPTH),
  localparam int ADDR_W    = BANK_W + OFF_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2*NUM_CORES-1:0]      enable,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  input  logic [NUM_CORES*DATA_W-1:0] wr_data,
  output logic [NUM_CORES*DATA_W-1:0] rd_data,
  output logic [NUM_CORES-1:0]        ready
`ifdef SH_MEM_CONFLICT_CNT_EN
  ,
  output logic [NUM_BANKS*CNT_W-1:0]  conflict_cnt
`endif
);

  localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [1:0]          op      [NUM_CORES];
  logic [BANK_W-1:0]   bank_of [NUM_CORES];
  logic [OFF_W-1:0]    off_of  [NUM_CORES];
  logic [DATA_W-1:0]   wd_of   [NUM_CORES];

  logic [NUM_CORES-1:0] elig    [NUM_BANKS];
  logic                 gnt_any [NUM_BANKS];
  logic [CORE_W-1:0]    win     [NUM_BANKS];
  logic [CORE_W-1:0]    ptr_q   [NUM_BANKS];
  logic [CORE_W-1:0]    ptr_nxt [NUM_BANKS];
  logic [NUM_CORES-1:0] gnt;

  logic                 we      [NUM_BANKS];
  logic                 re      [NUM_BANKS];
  logic [OFF_W-1:0]     b_addr  [NUM_BANKS];
  logic [DATA_W-1:0]    b_wdata [NUM_BANKS];
  logic [DATA_W-1:0]    b_rdata [NUM_BANKS];

  logic [NUM_CORES-1:0] ready_q;
  logic [NUM_CORES-1:0] rd_q;
  logic [BANK_W-1:0]    bsel_q [NUM_CORES];

  // split flat request buses into per-core fields
  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      op[c]      = enable[2*c +: 2];
      bank_of[c] = addr[c*ADDR_W+OFF_W +: BANK_W];
      off_of[c]  = addr[c*ADDR_W +: OFF_W];
      wd_of[c]   = wr_data[c*DATA_W +: DATA_W];
    end
  end

  // per-bank round-robin; a core in its ready cycle is not eligible
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      elig[b]    = '0;
      gnt_any[b] = 1'b0;
      win[b]     = '0;
      ptr_nxt[b] = ptr_q[b];
      for (int c = 0; c < NUM_CORES; c++) begin
        elig[b][c] = (op[c] != EN_IDLE) &&
                     (bank_of[c] == BANK_W'(b)) &&
                     !ready_q[c];
      end
      for (int k = 0; k < NUM_CORES; k++) begin
        j = int'(ptr_q[b]) + k;
        if (j >= NUM_CORES) j = j - NUM_CORES;
        if (!gnt_any[b] && elig[b][j]) begin
          gnt_any[b] = 1'b1;
          win[b]     = CORE_W'(j);
        end
      end
      if (gnt_any[b]) begin
        gnt[win[b]] = 1'b1;
        ptr_nxt[b]  = (win[b] == CORE_W'(NUM_CORES-1)) ?
                      '0 : CORE_W'(win[b] + 1'b1);
      end
      we[b]      = gnt_any[b] && op[win[b]][1] && !reset;
      re[b]      = gnt_any[b] && (op[win[b]] == EN_RD);
      b_addr[b]  = off_of[win[b]];
      b_wdata[b] = wd_of[win[b]];
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sh_mem_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (BANK_DEPTH)
    ) u_bank (
      .clk   (clk),
      .we    (we[b]),
      .re    (re[b]),
      .addr  (b_addr[b]),
      .wdata (b_wdata[b]),
      .rdata (b_rdata[b])
    );
  end

  // completion strobes, read flags and pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= '0;
      rd_q    <= '0;
      for (int b = 0; b < NUM_BANKS; b++) ptr_q[b] <= '0;
    end else begin
      ready_q <= gnt;
      for (int c = 0; c < NUM_CORES; c++)
        rd_q[c] <= gnt[c] && (op[c] == EN_RD);
      for (int b = 0; b < NUM_BANKS; b++) ptr_q[b] <= ptr_nxt[b];
    end
  end

  // remember which bank each core's read data comes from
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CORES; c++) bsel_q[c] <= bank_of[c];
  end

  // route bank read data back, zero when no read completes
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CORES; c++)
      rd_data[c*DATA_W +: DATA_W] = rd_q[c] ? b_rdata[bsel_q[c]] : '0;
  end

  assign ready = ready_q;

`ifdef SH_MEM_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_BANKS];

  // saturating count of cycles with 2+ eligible requesters
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++)
        if ($countones(elig[b]) > 1 && cnt_q[b] != '1)
          cnt_q[b] <= cnt_q[b] + 1'b1;
    end
  end

  // flatten counters onto the output port
  always_comb begin
    conflict_cnt = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      conflict_cnt[b*CNT_W +: CNT_W] = cnt_q[b];
  end
`endif

endmodule

// File: tb/tb_sh_mem_banked.sv
// Directed testbench for sh_mem_banked (default 4 cores, 4 banks).
// Conflict counter scenario runs only with SH_MEM_CONFLICT_CNT_EN.
module tb_sh_mem_banked;

  logic        clk;
  logic        reset;
  logic [7:0]  enable;
  logic [39:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [3:0]  ready;
`ifdef SH_MEM_CONFLICT_CNT_EN
  logic [63:0] conflict_cnt;
`endif

  int checks;
  int failures;

  sh_mem_banked dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .ready   (ready)
`ifdef SH_MEM_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int c, input logic [1:0] op,
                          input logic [9:0] a, input logic [7:0] d);
    enable[2*c +: 2]  = op;
    addr[c*10 +: 10]  = a;
    wr_data[c*8 +: 8] = d;
  endtask

  task automatic all_idle();
    enable  = '0;
    addr    = '0;
    wr_data = '0;
  endtask

  task automatic test_reset();
    all_idle();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=%b", ready, 4'b0000);
    end
    checks++;
    if (rd_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_rd_data got=%h exp=%h", rd_data, 32'h0);
    end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    set_core(0, 2'b10, 10'h005, 8'hA5);
    step();
    checks++;
    if (ready !== 4'b0001) begin
      failures++;
      $display("FAIL wr_ready got=%b exp=%b", ready, 4'b0001);
    end
    checks++;
    if (rd_data !== 32'h0) begin
      failures++;
      $display("FAIL wr_rd_data got=%h exp=%h", rd_data, 32'h0);
    end
    all_idle();
    step();
    checks++;
    if (ready !== 4'b0000) begin
      failures++;
      $display("FAIL wr_ready_one got=%b exp=%b", ready, 4'b0000);
    end
    set_core(0, 2'b01, 10'h005, 8'h00);
    step();
    checks++;
    if (ready !== 4'b0001) begin
      failures++;
      $display("FAIL rd_ready got=%b exp=%b", ready, 4'b0001);
    end
    checks++;
    if (rd_data !== 32'h0000_00A5) begin
      failures++;
      $display("FAIL rd_data got=%h exp=%h", rd_data, 32'h0000_00A5);
    end
    all_idle();
    step();
    checks++;
    if (ready !== 4'b0000 || rd_data !== 32'h0) begin
      failures++;
      $display("FAIL rd_after got=%b/%h exp=0000/0", ready, rd_data);
    end
  endtask

  task automatic test_parallel();
    for (int c = 0; c < 4; c++) begin
      logic [9:0] a;
      a = {c[1:0], 8'h10};
      set_core(c, 2'b10, a, 8'h10 + 8'(c));
    end
    step();
    checks++;
    if (ready !== 4'b1111) begin
      failures++;
      $display("FAIL par_wr_ready got=%b exp=%b", ready, 4'b1111);
    end
    all_idle();
    step();
    for (int c = 0; c < 4; c++) begin
      logic [9:0] a;
      a = {c[1:0], 8'h10};
      set_core(c, 2'b01, a, 8'h00);
    end
    step();
    checks++;
    if (ready !== 4'b1111) begin
      failures++;
      $display("FAIL par_rd_ready got=%b exp=%b", ready, 4'b1111);
    end
    checks++;
    if (rd_data !== 32'h1312_1110) begin
      failures++;
      $display("FAIL par_rd_data got=%h exp=%h", rd_data, 32'h1312_1110);
    end
    all_idle();
    step();
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 4; k++) begin
      set_core(0, 2'b10, 10'h100 + 10'(k), 8'h30 + 8'(k));
      step();
      all_idle();
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 4; c++)
      set_core(c, 2'b01, 10'h100 + 10'(c), 8'h00);
    for (int i = 0; i < 8; i++) begin
      logic [3:0]  exp_rdy;
      logic [31:0] exp_rd;
      int          k;
      k       = i % 4;
      exp_rdy = 4'b0001 << k;
      exp_rd  = 32'(8'h30 + 8'(k)) << (8 * k);
      step();
      checks++;
      if (ready !== exp_rdy) begin
        failures++;
        $display("FAIL rr_ready[%0d] got=%b exp=%b", i, ready, exp_rdy);
      end
      checks++;
      if (rd_data !== exp_rd) begin
        failures++;
        $display("FAIL rr_rd_data[%0d] got=%h exp=%h", i, rd_data, exp_rd);
      end
    end
    all_idle();
    step();
  endtask

  task automatic test_reset_write();
    set_core(2, 2'b10, 10'h207, 8'h5A);
    step();
    all_idle();
    step();
    set_core(2, 2'b10, 10'h207, 8'hEE);
    reset = 1'b1;
    step();
    checks++;
    if (ready !== 4'b0000 || rd_data !== 32'h0) begin
      failures++;
      $display("FAIL rst_wr_ready got=%b/%h exp=0000/0", ready, rd_data);
    end
    reset = 1'b0;
    all_idle();
    step();
    checks++;
    if (ready[2] !== 1'b0) begin
      failures++;
      $display("FAIL rst_wr_no_ready got=%b exp=0", ready[2]);
    end
    set_core(2, 2'b01, 10'h207, 8'h00);
    step();
    checks++;
    if (ready !== 4'b0100 || rd_data !== 32'h005A_0000) begin
      failures++;
      $display("FAIL rst_wr_mem got=%b/%h exp=0100/005a0000",
               ready, rd_data);
    end
    all_idle();
    step();
  endtask

  task automatic test_write_nr();
    set_core(1, 2'b11, 10'h1FF, 8'h77);
    step();
    checks++;
    if (ready !== 4'b0010) begin
      failures++;
      $display("FAIL wnr_ready got=%b exp=%b", ready, 4'b0010);
    end
    checks++;
    if (rd_data !== 32'h0) begin
      failures++;
      $display("FAIL wnr_rd_data got=%h exp=%h", rd_data, 32'h0);
    end
    all_idle();
    step();
    set_core(1, 2'b01, 10'h1FF, 8'h00);
    step();
    checks++;
    if (ready !== 4'b0010 || rd_data !== 32'h0000_7700) begin
      failures++;
      $display("FAIL wnr_readback got=%b/%h exp=0010/00007700",
               ready, rd_data);
    end
    all_idle();
    step();
  endtask

`ifdef SH_MEM_CONFLICT_CNT_EN
  task automatic test_conflict();
    reset = 1'b1;
    step();
    checks++;
    if (conflict_cnt !== 64'h0) begin
      failures++;
      $display("FAIL cnt_reset got=%h exp=0", conflict_cnt);
    end
    reset = 1'b0;
    // a third core keeps two requesters eligible during ready cycles
    for (int c = 0; c < 3; c++)
      set_core(c, 2'b01, 10'h300 + 10'(c), 8'h00);
    repeat (10) step();
    checks++;
    if (conflict_cnt !== 64'h000A_0000_0000_0000) begin
      failures++;
      $display("FAIL cnt_10 got=%h exp=%h",
               conflict_cnt, 64'h000A_0000_0000_0000);
    end
    repeat (70000) step();
    checks++;
    if (conflict_cnt[63:48] !== 16'hFFFF) begin
      failures++;
      $display("FAIL cnt_sat got=%h exp=ffff", conflict_cnt[63:48]);
    end
    checks++;
    if (conflict_cnt[47:0] !== 48'h0) begin
      failures++;
      $display("FAIL cnt_other got=%h exp=0", conflict_cnt[47:0]);
    end
    all_idle();
    step();
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    all_idle();
    test_reset();
    test_write_read();
    test_parallel();
    test_round_robin();
    test_reset_write();
    test_write_nr();
`ifdef SH_MEM_CONFLICT_CNT_EN
    test_conflict();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
